// File: rtl/spi_ctrl_responder.sv
// spi_ctrl_responder: write-only 3-wire SPI target for 16-bit codec control
// words (7-bit address, 9-bit data, MSB first). Accepted words are written
// into a small register file and announced with a one-cycle strobe.
//
// Ports:
//   clk, resetn           system clock (>= 4x SCLK), async active-low reset
//   spi_sck, spi_mosi, cs asynchronous SPI pins (oversampled)
//   wr_valid              one-cycle strobe per accepted frame
//   wr_addr, wr_data      fields of the last accepted frame (held)
//   addr_oor              pulse with wr_valid when wr_addr >= NREGS
//   frame_err             pulse when cs rises with a bit count != WORDSIZE
//   rd_addr, rd_data      registered readback, 1-cycle latency
//   frame_count           accepted-frame counter, wraps
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_IDLE | after reset, wait for cs high so a partial frame is ignored
// IDLE      | bus idle, wait for cs falling edge
// SHIFT     | shifting bits on sck rising edges until cs rises
// LATCH     | one cycle: publish the frame and update the register file
module spi_ctrl_responder #(
  parameter int WORDSIZE   = 16,
  parameter int ADDRBITS   = 7,
  parameter int DATABITS   = 9,
  parameter int NREGS      = 16,
  parameter int RESET_ADDR = 15
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     spi_sck,
  input  logic                     spi_mosi,
  input  logic                     cs,
  output logic                     wr_valid,
  output logic [ADDRBITS-1:0]      wr_addr,
  output logic [DATABITS-1:0]      wr_data,
  output logic                     addr_oor,
  output logic                     frame_err,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [DATABITS-1:0]      rd_data,
  output logic [15:0]              frame_count
);

  localparam int                  RAW        = $clog2(NREGS);
  localparam logic [ADDRBITS-1:0] NREGS_A    = ADDRBITS'(NREGS);
  localparam logic [ADDRBITS-1:0] RESET_A    = ADDRBITS'(RESET_ADDR);
  localparam logic [4:0]          WS_C       = 5'(WORDSIZE);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, LATCH} state_t;

  state_t                state_q, state_d;
  logic [2:0]            sck_sync_q, sck_sync_d;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  logic [2:0]            cs_sync_q, cs_sync_d;
  logic [WORDSIZE-1:0]   shreg_q, shreg_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDRBITS-1:0]   wr_addr_q, wr_addr_d;
  logic [DATABITS-1:0]   wr_data_q, wr_data_d;
  logic                  addr_oor_q, addr_oor_d;
  logic                  frame_err_q, frame_err_d;
  logic [DATABITS-1:0]   rd_data_q, rd_data_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [DATABITS-1:0]   regs_q [NREGS];
  logic [DATABITS-1:0]   regs_d [NREGS];

  logic                  sck_rise, cs_rise, cs_fall;
  logic [ADDRBITS-1:0]   lat_addr;
  logic [DATABITS-1:0]   lat_data;

  always_comb begin
    sck_sync_d    = {sck_sync_q[1:0], spi_sck};
    mosi_sync_d   = {mosi_sync_q[0], spi_mosi};
    cs_sync_d     = {cs_sync_q[1:0], cs};
    sck_rise      = sck_sync_q[1] & ~sck_sync_q[2];
    cs_rise       = cs_sync_q[1] & ~cs_sync_q[2];
    cs_fall       = ~cs_sync_q[1] & cs_sync_q[2];
    lat_addr      = shreg_q[WORDSIZE-1:DATABITS];
    lat_data      = shreg_q[DATABITS-1:0];

    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    wr_valid_d    = 1'b0;
    addr_oor_d    = 1'b0;
    frame_err_d   = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_count_d = frame_count_q;
    regs_d        = regs_q;
    // Read uses the pre-write contents: a same-cycle write shows up next cycle.
    rd_data_d     = regs_q[rd_addr];

    case (state_q)
      WAIT_IDLE: if (cs_sync_q[1]) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Shift first so an sck rise coinciding with cs rise is counted.
        if (sck_rise) begin
          shreg_d = {shreg_q[WORDSIZE-2:0], mosi_sync_q[1]};
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end
        if (cs_rise) begin
          if (cnt_d == WS_C) begin
            state_d = LATCH;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      LATCH: begin
        wr_valid_d    = 1'b1;
        wr_addr_d     = lat_addr;
        wr_data_d     = lat_data;
        frame_count_d = frame_count_q + 16'd1;
        if (lat_addr == RESET_A) begin
          for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
        end else if (lat_addr < NREGS_A) begin
          regs_d[lat_addr[RAW-1:0]] = lat_data;
        end else begin
          addr_oor_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= WAIT_IDLE;
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      cs_sync_q     <= '0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      addr_oor_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      rd_data_q     <= '0;
      frame_count_q <= '0;
      regs_q        <= '{default: '0};
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      cs_sync_q     <= cs_sync_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      addr_oor_q    <= addr_oor_d;
      frame_err_q   <= frame_err_d;
      rd_data_q     <= rd_data_d;
      frame_count_q <= frame_count_d;
      regs_q        <= regs_d;
    end
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign addr_oor    = addr_oor_q;
  assign frame_err   = frame_err_q;
  assign rd_data     = rd_data_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_spi_ctrl_responder.sv
// Testbench for spi_ctrl_responder: directed scenarios plus random frames,
// compared against a word-level model of the register file and counters.
module tb_spi_ctrl_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        cs = 1'b1;
  logic        wr_valid;
  logic [6:0]  wr_addr;
  logic [8:0]  wr_data;
  logic        addr_oor;
  logic        frame_err;
  logic [3:0]  rd_addr = 4'd0;
  logic [8:0]  rd_data;
  logic [15:0] frame_count;

  spi_ctrl_responder dut (
    .clk(clk), .resetn(resetn), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .cs(cs),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .addr_oor(addr_oor), .frame_err(frame_err), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [6:0] a;
    logic [8:0] d;
    logic       oor;
    int         c;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [8:0] m_regs [16];
  int         m_count = 0;
  int         exp_err = 0;
  int         obs_err = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(string tag, longint obs, longint expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  // Output monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (frame_err) obs_err++;
    if (wr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", wr_addr, mon_e.a);
        chk("wr_data", wr_data, mon_e.d);
        chk("addr_oor", addr_oor, mon_e.oor);
        chk("wr_latency", cyc, mon_e.c);
      end
    end else if (addr_oor) begin
      chk("oor_without_valid", 1, 0);
    end
  end

  // Word-level reference: what a complete frame of nbits should do.
  task automatic model_frame(logic [31:0] bits, int nbits, int rise_cyc);
    exp_t       e;
    logic [6:0] a;
    if (nbits != 16) begin
      exp_err++;
      return;
    end
    a       = bits[15:9];
    e.a     = a;
    e.d     = bits[8:0];
    e.oor   = (a >= 7'd16);
    e.c     = rise_cyc + 4;
    m_count = (m_count + 1) % 65536;
    exp_q.push_back(e);
    if (a == 7'd15) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
    end else if (a < 7'd16) begin
      m_regs[int'(a)] = bits[8:0];
    end
  endtask

  task automatic shift_bits(logic [31:0] bits, int hi, int lo);
    for (int i = hi; i >= lo; i--) begin
      spi_mosi = bits[i];
      repeat (2) @(negedge clk);
      spi_sck = 1'b1;
      repeat (2) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_frame(logic [31:0] bits, int nbits, int gap);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    shift_bits(bits, nbits - 1, 0);
    repeat (2) @(negedge clk);
    cs = 1'b1;
    model_frame(bits, nbits, cyc);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(string tag);
    repeat (10) @(negedge clk);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_frame_err_cnt"}, obs_err, exp_err);
    chk({tag, "_frame_count"}, frame_count, m_count);
  endtask

  task automatic check_regs();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(negedge clk);
      chk($sformatf("rd_reg%0d", a), rd_data, m_regs[a]);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  ra;
    int          nb;
    bit          seen;

    for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
    repeat (3) @(negedge clk);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_rd_data", rd_data, 0);
    resetn = 1'b1;
    repeat (6) @(negedge clk);

    // Normal write: addr 4, data 0x012.
    send_frame(32'h0812, 16, 8);
    wait_drain("normal");
    rd_addr = 4'd4;
    @(negedge clk);
    chk("normal_rd4", rd_data, 9'h012);
    chk("normal_count", frame_count, 1);

    // Short and long frames are rejected and leave fields alone.
    send_frame($urandom, 15, 8);
    send_frame($urandom, 17, 8);
    wait_drain("badlen");
    chk("badlen_errs", obs_err, 2);
    chk("hold_wr_addr", wr_addr, 7'h04);
    chk("hold_wr_data", wr_data, 9'h012);
    check_regs();

    // Out-of-range address, then reset address after filling 0..3.
    send_frame({16'd0, 7'h20, 9'h0AB}, 16, 8);
    for (int a = 0; a < 4; a++) send_frame({16'd0, 7'(a), 9'($urandom)}, 16, 6);
    wait_drain("fill");
    check_regs();
    send_frame({16'd0, 7'h0F, 9'h000}, 16, 8);
    wait_drain("clear");
    check_regs();

    // Reset mid-frame: the tail of the frame must be ignored.
    w = {16'd0, 7'd2, 9'h155};
    cs = 1'b0;
    repeat (2) @(negedge clk);
    shift_bits(w, 15, 8);
    resetn = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
    m_count = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("midrst_count", frame_count, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    shift_bits(w, 7, 0);
    repeat (2) @(negedge clk);
    cs = 1'b1;
    wait_drain("midrst");
    send_frame({16'd0, 7'd6, 9'h0C3}, 16, 8);
    wait_drain("after_rst");
    check_regs();

    // Back-to-back frames with one SCLK period of cs-high gap.
    for (int k = 0; k < 3; k++) send_frame({16'd0, 7'(k + 8), 9'($urandom)}, 16, 4);
    wait_drain("b2b");
    chk("b2b_count", frame_count, 4);

    // Readback collision on register 4.
    send_frame({16'd0, 7'd4, 9'h012}, 16, 8);
    wait_drain("coll_pre");
    rd_addr = 4'd4;
    send_frame({16'd0, 7'd4, 9'h1FF}, 16, 0);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (wr_valid) seen = 1'b1;
    end
    chk("coll_seen", seen, 1);
    chk("coll_old", rd_data, 9'h012);
    @(negedge clk);
    chk("coll_new", rd_data, 9'h1FF);
    wait_drain("coll");

    // cs glitch without clocks.
    send_frame(32'd0, 0, 6);
    wait_drain("glitch");

    // Random traffic.
    for (int k = 0; k < 30; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(16, 127)) : 7'($urandom_range(0, 14));
      if ($urandom_range(0, 19) == 0) ra = 7'd15;
      case ($urandom_range(0, 9))
        0: nb = 15;
        1: nb = 17;
        2: nb = 0;
        default: nb = 16;
      endcase
      w = (nb == 16) ? {16'd0, ra, 9'($urandom)} : 32'($urandom);
      send_frame(w, nb, $urandom_range(4, 10));
    end
    wait_drain("random");
    check_regs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
